fix_sqrt_iter: RTL and testbench
================================

// Module: fix_sqrt_iter
// PURPOSE
//  Iterative unsigned fixed-point square root: the inverse of the fixed-point squarer
//  (x**2) path. Takes a Q(IN_BW-IN_PNT).IN_PNT value and returns floor(sqrt(x)) in
//  Q(OUT_BW-OUT_PNT).OUT_PNT, one root bit per clock (restoring, digit-by-digit).
//  Sits downstream of the power stage with valid/ready on both sides.
// PARAMETERS
//  IN_BW    9  input word width (unsigned)
//  IN_PNT   7  input fractional bits
//  OUT_BW   9  output word width (unsigned)
//  OUT_PNT  7  output fractional bits; requires 2*OUT_PNT >= IN_PNT (elab $error otherwise)
//  derived: SH = 2*OUT_PNT-IN_PNT; RAD_BW = IN_BW+SH rounded up to even;
//           RT_BW = RAD_BW/2; N_IT = RT_BW (defaults: SH=7, RAD_BW=16, RT_BW=8, N_IT=8)
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       in_data valid
//  in_ready   out  1       block can accept (IDLE only)
//  in_data    in   IN_BW   radicand, Q(IN_BW-IN_PNT).IN_PNT
//  out_valid  out  1       result valid, held until out_ready
//  out_ready  in   1       downstream accepts
//  out_data   out  OUT_BW  floor(sqrt(in_data)), Q(OUT_BW-OUT_PNT).OUT_PNT
//  out_exact  out  1       final remainder == 0 (root exact at output precision)
//  out_sat    out  1       root did not fit OUT_BW; out_data clamped to all ones
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_exact=0, out_sat=0;
//    datapath regs cleared. rst mid-CALC or in DONE discards the job, no output.
//  - Math: R = zero-extended in_data << SH (RAD_BW bits); root = floor(sqrt(R)), RT_BW bits;
//    out_data = root zero-extended if RT_BW <= OUT_BW or root < 2**OUT_BW,
//    else all ones with out_sat=1. out_exact = (R - root*root == 0), cleared when sat.
//  - FSM IDLE -> CALC -> DONE -> IDLE:
//    IDLE: in_ready=1; on in_valid&&in_ready load R, rem=0, root=0, cnt=N_IT-1 -> CALC.
//    CALC: in_ready=0; per cycle shift next 2 radicand MSBs into rem,
//      trial = {root,2'b01}; if rem >= trial {rem-=trial; root={root,1}} else root={root,0};
//      cnt==0 -> DONE, else cnt--. rem width RT_BW+2, no overflow possible.
//    DONE: out_valid=1, out_data/out_exact/out_sat stable; on out_ready -> IDLE.
//  - Latency: out_valid rises N_IT clocks after the accepting edge (8 at defaults).
//    Throughput: one result per N_IT+2 clocks minimum (no overlap).
//  - in_ready is a pure function of state (no comb path from out_ready).
//    in_data sampled only on the accepting edge; later changes ignored.
//  - out_ready while out_valid=0 is ignored. in_valid outside IDLE is not consumed.
//  - out_data holds the last result after handoff until the next DONE (don't-care
//    when out_valid=0; bench must not check it then).
//  - in_data=0 -> root 0, out_exact=1. Max input handled without overflow.
// TESTING (defaults)
//  1. in_data=9'h080 (1.0) -> out_data=9'h080, out_exact=1, out_valid 8 clks after accept
//  2. in_data=9'h120 (2.25) -> 9'h0C0 (1.5), exact=1; in_data=9'h100 (2.0) -> 9'h0B5, exact=0
//  3. in_data=9'h040 (0.5) -> 9'h05A, exact=0; in_data=9'h1FF -> 9'h0FF, exact=0, sat=0
//  4. in_data=0 -> 9'h000, exact=1; back-to-back in_valid held high: second job accepted
//     only after DONE handoff, in_ready=0 throughout CALC/DONE
//  5. out_ready held low 20 clks in DONE -> out_valid/out_data stable; release -> IDLE next clk
//  6. rst asserted at CALC iteration 4 -> next clk IDLE, in_ready=1, no out_valid; new job
//     then produces correct result; random sweep of all 512 inputs vs floor(sqrt) model

Source files
------------

// File: rtl/fix_sqrt_iter.sv
// fix_sqrt_iter: iterative restoring fixed-point square root, one root bit per clock
module fix_sqrt_iter #(
  parameter int IN_BW = 9,
  parameter int IN_PNT = 7,
  parameter int OUT_BW = 9,
  parameter int OUT_PNT = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_BW-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_BW-1:0] out_data,
  output logic              out_exact,
  output logic              out_sat
);
  localparam int SH = 2*OUT_PNT - IN_PNT;
  localparam int RAW = IN_BW + SH;
  localparam int RAD_BW = RAW + (RAW % 2);
  localparam int RT_BW = RAD_BW / 2;
  localparam int N_IT = RT_BW;
  localparam int CW = N_IT > 1 ? $clog2(N_IT) : 1;
  localparam int W = RT_BW > OUT_BW ? RT_BW : OUT_BW;
  if (2*OUT_PNT < IN_PNT) begin : g_chk
    $error("fix_sqrt_iter: OUT_PNT too small for IN_PNT");
  end
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_d;
  logic [RAD_BW-1:0] rad;
  logic [RT_BW+1:0] rem, rem_sh, trial, rem_n;
  logic [RT_BW-1:0] root, root_n;
  logic [CW-1:0] cnt;
  logic [W-1:0] root_w;
  logic ge, sat;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_d;
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    state_d = (state == IDLE && in_valid) ? CALC :
              (state == CALC && cnt == '0) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  // rem never exceeds 2*root, so its low RT_BW bits carry the whole value before the shift
  always_comb begin
    rem_sh = (rem << 2) | (RT_BW+2)'(rad[RAD_BW-1 -: 2]);
    trial = {root, 2'b01};
    ge = rem_sh >= trial;
    rem_n = ge ? rem_sh - trial : rem_sh;
    root_n = {root[RT_BW-2:0], ge};
    root_w = W'(root_n);
    sat = (root_w >> OUT_BW) != '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      rad <= '0;
      rem <= '0;
      root <= '0;
      cnt <= '0;
      out_data <= '0;
      out_exact <= 1'b0;
      out_sat <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      rad <= RAD_BW'(in_data) << SH;
      rem <= '0;
      root <= '0;
      cnt <= CW'(N_IT - 1);
    end else if (state == CALC) begin
      rad <= rad << 2;
      rem <= rem_n;
      root <= root_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        out_data <= sat ? '1 : root_w[OUT_BW-1:0];
        out_exact <= !sat && rem_n == '0;
        out_sat <= sat;
      end
    end
endmodule

// File: tb/tb_fix_sqrt_iter.sv
// tb_fix_sqrt_iter: scoreboard bench for fix_sqrt_iter at default parameters
module tb_fix_sqrt_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [8:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [8:0] out_data;
  logic out_exact, out_sat;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic [8:0] d; logic e; logic s;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  logic [8:0] order [512];
  fix_sqrt_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exact(out_exact), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [8:0] x);
    longint r, rr;
    rr = longint'(x) << 7;
    r = 0;
    while ((r + 1) * (r + 1) <= rr) r++;
    return '{d: 9'(r), e: (r * r == rr), s: 1'b0};
  endfunction
  task automatic send(input logic [8:0] d, input exp_t e);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      q.push_back(e);
      @(posedge clk); #1;
    end
  endtask
  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask
  always @(negedge clk)
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        mon_e = q.pop_front();
        chk("out_data", out_data, mon_e.d);
        chk("out_exact", out_exact, mon_e.e);
        chk("out_sat", out_sat, mon_e.s);
      end
    end
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end
  initial begin
    bit seen;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_exact", out_exact, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    send(9'h080, '{d: 9'h080, e: 1'b1, s: 1'b0});
    in_valid = 1'b0;
    chk("calc_in_ready", in_ready, 0);
    repeat (7) @(posedge clk);
    #1;
    chk("latency_7", out_valid, 0);
    @(posedge clk); #1;
    chk("latency_8", out_valid, 1);
    chk("done_in_ready", in_ready, 0);
    send(9'h120, '{d: 9'h0C0, e: 1'b1, s: 1'b0});
    send(9'h100, '{d: 9'h0B5, e: 1'b0, s: 1'b0});
    send(9'h040, '{d: 9'h05A, e: 1'b0, s: 1'b0});
    send(9'h1FF, '{d: 9'h0FF, e: 1'b0, s: 1'b0});
    send(9'h000, '{d: 9'h000, e: 1'b1, s: 1'b0});
    in_data = 9'h120;
    for (int k = 0; k < 8; k++) begin
      chk("b2b_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    send(9'h120, '{d: 9'h0C0, e: 1'b1, s: 1'b0});
    in_valid = 1'b0;
    wait_out();
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(9'h100, '{d: 9'h0B5, e: 1'b0, s: 1'b0});
    in_valid = 1'b0;
    wait_out();
    for (int k = 0; k < 20; k++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 9'h0B5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    send(9'h120, '{d: 9'h0C0, e: 1'b1, s: 1'b0});
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q.pop_back());
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("abort_no_output", seen, 0);
    send(9'h040, '{d: 9'h05A, e: 1'b0, s: 1'b0});
    in_valid = 1'b0;
    for (int i = 0; i < 512; i++) order[i] = 9'(i);
    for (int i = 511; i > 0; i--) begin
      int j;
      logic [8:0] t;
      j = $urandom_range(0, i);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 512; i++) begin
      send(order[i], model(order[i]));
      in_valid = 1'b0;
    end
    n = 0;
    while (q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    chk("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
